// File: rtl/tinyalu_pkg.sv
// Shared opcode and arbiter-state types for the tinyalu arbiter slice.
// Opcode classification helpers used by the arbiter FSM.
package tinyalu_pkg;

    typedef enum logic [2:0] {
        OP_NOP = 3'd0,
        OP_ADD = 3'd1,
        OP_AND = 3'd2,
        OP_XOR = 3'd3,
        OP_MUL = 3'd4
    } op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        GAP   = 2'd2
    } arb_state_e;

    function automatic logic is_legal_op(input logic [2:0] op);
        return op <= OP_MUL;
    endfunction

    // NOP is legal but never touches the ALU.
    function automatic logic uses_alu(input logic [2:0] op);
        return (op != OP_NOP) && is_legal_op(op);
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant, combinational from req_valid; zero latency.
// last_grant only moves on accept, so a stalled winner keeps its priority.
module rr_arb2 (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] req_valid,
    input  logic       accept,
    output logic [1:0] grant
);

    logic last_grant;

    always_comb begin
        grant = req_valid;
        if (req_valid == 2'b11) begin
            grant = last_grant ? 2'b01 : 2'b10;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant <= 1'b1;
        end else if (accept) begin
            last_grant <= grant[1];
        end
    end

endmodule

// File: rtl/tinyalu_arbiter.sv
// Shares one tinyalu between two requesters; ALU ops answer one cycle after done, NOP/illegal next cycle.
// Backpressure: reqN_ready only in IDLE, one command outstanding; a watchdog aborts a hung ALU.
module tinyalu_arbiter
    import tinyalu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [7:0]  req0_a,
    input  logic [7:0]  req0_b,
    input  logic [2:0]  req0_op,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [7:0]  req1_a,
    input  logic [7:0]  req1_b,
    input  logic [2:0]  req1_op,
    output logic        rsp0_valid,
    output logic        rsp1_valid,
    output logic [15:0] rsp_result,
    output logic        rsp_err,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic [2:0]  alu_op,
    output logic        alu_start,
    input  logic        alu_done,
    input  logic [15:0] alu_result
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    arb_state_e       state_q, state_d;
    logic [CNT_W-1:0] wd_q, wd_d;
    logic             owner_q, owner_d;
    logic [7:0]       a_d, b_d;
    logic [2:0]       op_d;
    logic             start_d;
    logic             rsp0_d, rsp1_d, err_d;
    logic [15:0]      res_d;

    logic [1:0]       grant;
    logic             accept;
    logic [7:0]       sel_a, sel_b;
    logic [2:0]       sel_op;
    logic             timeout;

    rr_arb2 u_rr_arb2 (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid ({req1_valid, req0_valid} & {2{state_q == IDLE}}),
        .accept    (accept),
        .grant     (grant)
    );

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];
    assign accept     = |grant;
    assign sel_a      = grant[1] ? req1_a  : req0_a;
    assign sel_b      = grant[1] ? req1_b  : req0_b;
    assign sel_op     = grant[1] ? req1_op : req0_op;
    // wd_q counts completed ISSUE cycles, so this is the TIMEOUT_CYCLES-th cycle of alu_start.
    assign timeout    = (wd_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_d = state_q;
        wd_d    = wd_q;
        owner_d = owner_q;
        a_d     = alu_a;
        b_d     = alu_b;
        op_d    = alu_op;
        start_d = alu_start;
        rsp0_d  = 1'b0;
        rsp1_d  = 1'b0;
        res_d   = rsp_result;
        err_d   = rsp_err;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    owner_d = grant[1];
                    if (uses_alu(sel_op)) begin
                        a_d     = sel_a;
                        b_d     = sel_b;
                        op_d    = sel_op;
                        start_d = 1'b1;
                        wd_d    = '0;
                        state_d = ISSUE;
                    end else begin
                        rsp0_d = grant[0];
                        rsp1_d = grant[1];
                        res_d  = '0;
                        err_d  = !is_legal_op(sel_op);
                    end
                end
            end
            ISSUE: begin
                wd_d = wd_q + 1'b1;
                if (alu_done) begin
                    rsp0_d  = !owner_q;
                    rsp1_d  = owner_q;
                    res_d   = alu_result;
                    err_d   = 1'b0;
                    start_d = 1'b0;
                    state_d = GAP;
                end else if (timeout) begin
                    rsp0_d  = !owner_q;
                    rsp1_d  = owner_q;
                    res_d   = '0;
                    err_d   = 1'b1;
                    start_d = 1'b0;
                    state_d = GAP;
                end
            end
            GAP: begin
                // The single-cycle unit echoes done once here; it is deliberately ignored.
                a_d     = '0;
                b_d     = '0;
                op_d    = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            wd_q       <= '0;
            owner_q    <= 1'b0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_op     <= '0;
            alu_start  <= 1'b0;
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp_result <= '0;
            rsp_err    <= 1'b0;
        end else begin
            state_q    <= state_d;
            wd_q       <= wd_d;
            owner_q    <= owner_d;
            alu_a      <= a_d;
            alu_b      <= b_d;
            alu_op     <= op_d;
            alu_start  <= start_d;
            rsp0_valid <= rsp0_d;
            rsp1_valid <= rsp1_d;
            rsp_result <= res_d;
            rsp_err    <= err_d;
        end
    end

endmodule

// File: doc/tinyalu_arbiter.md
Name: tinyalu_arbiter

Overview:
- Shares one tinyalu between two requesters.
- Round-robin arbitration over two valid/ready request channels.
- Drives the ALU start/operand handshake for the correct duration per opcode class.
- Returns results on per-requester response pulses; a watchdog aborts hung operations.

Parameters:
- TIMEOUT_CYCLES, 15: max cycles alu_start stays high without alu_done before abort (legal 5..255).
- CNT_W, $clog2(TIMEOUT_CYCLES+1): watchdog counter width (derived, not overridden).

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- req0_valid  in  1  requester 0 command valid
- req0_ready  out  1  requester 0 command accepted this cycle
- req0_a  in  8  requester 0 operand A
- req0_b  in  8  requester 0 operand B
- req0_op  in  3  requester 0 opcode
- req1_valid, req1_ready, req1_a, req1_b, req1_op: same as requester 0
- rsp0_valid  out  1  one-cycle response pulse to requester 0
- rsp1_valid  out  1  one-cycle response pulse to requester 1
- rsp_result  out  16  result, valid with rspN_valid
- rsp_err  out  1  illegal opcode or timeout, valid with rspN_valid
- alu_a  out  8  ALU operand A
- alu_b  out  8  ALU operand B
- alu_op  out  3  ALU opcode
- alu_start  out  1  ALU start
- alu_done  in  1  ALU done
- alu_result  in  16  ALU result

Behaviour:
- Opcodes: 000 NOP; 001 ADD; 010 AND; 011 XOR; 100 MUL; 101..111 ILLEGAL.
- Reset values: all outputs 0, state IDLE, last_grant=1 (requester 0 wins first tie), watchdog 0.
- Reset mid-operation: alu_start drops immediately; no response is issued for the aborted command.
- FSM states: IDLE, ISSUE, GAP.
- IDLE:
  - Grant is combinational round-robin: a single valid requester wins; if both are valid, the requester not in last_grant wins.
  - reqN_ready=1 only for the winner, and only in IDLE. Accept = valid&ready; last_grant updates on accept.
  - NOP or ILLEGAL accepted: no ALU activity. Next cycle rspN_valid=1 with rsp_result=0 and rsp_err = (op is ILLEGAL). Stay in IDLE; a new accept is allowed in the same cycle as that response.
  - ADD/AND/XOR/MUL accepted: register alu_a/alu_b/alu_op, set alu_start=1, clear watchdog, go to ISSUE.
- ISSUE:
  - alu_a/b/op/start held constant; watchdog increments each cycle.
  - alu_done=1: capture alu_result, pulse rspN_valid next cycle with rsp_err=0, drop alu_start at the same edge, go to GAP.
  - Watchdog == TIMEOUT_CYCLES without done: drop alu_start, pulse rspN_valid with rsp_result=0 and rsp_err=1, go to GAP.
  - Done and timeout in the same cycle: done wins.
- GAP: exactly one cycle with alu_start=0. alu_done is ignored here, because the single-cycle unit's done echoes once. Clear alu_a/b/op to 0, then go to IDLE. No accept in GAP.
- Latency, cycle 0 = accept cycle:
  - ADD/AND/XOR: start visible cycle 1, done cycle 2, response cycle 3.
  - MUL: done cycle 5, response cycle 6.
  - NOP/ILLEGAL: response cycle 1.
- rsp0_valid and rsp1_valid are never high together; at most one command is outstanding.
- Response result is exactly alu_result zero-extended as delivered; the arbiter does no arithmetic.

Decomposition:
- Package tinyalu_pkg: op_e enum (NOP, ADD, AND, XOR, MUL), arb_state_e (IDLE, ISSUE, GAP), function is_legal_op.
- Sub-module rr_arb2: 2-way round-robin grant with last_grant register and an update-on-accept input.

Test Plan:
- req0 ADD a=8'hFF b=8'h01 -> req0_ready cycle 0; alu_start cycles 1-2; rsp0_valid cycle 3, result 16'h0100, err 0.
- req1 MUL a=8'hFF b=8'hFF -> rsp1_valid cycle 6, result 16'hFE01; alu_start high exactly cycles 1-5, then GAP.
- Both valid every cycle, req0 XOR 8'hF0^8'h3C, req1 AND 8'hF0&8'h3C -> grants alternate 0,1,0,1; results 16'h00CC and 16'h0030.
- req0 op=3'b110 -> rsp0_valid cycle 1, result 0, err 1; alu_start never asserted.
- ALU model holds alu_done=0 on MUL -> alu_start high 15 cycles, then rsp err=1, result 0; next command completes normally.
- reset_n low during ISSUE of MUL -> alu_start low asynchronously; no response; after release, req1 wins first tie? No: req0 wins first tie (last_grant=1).
